rev_mux_sequencer: RTL and testbench



---
 rtl/rev_pkg.sv | 13 +
 rtl/rev_mux_sequencer.sv | 138 +++++++++++++
 tb/tb_rev_mux_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rev_pkg.sv
// Shared types and defaults for the reversible-mux operand sequencer.
package rev_pkg;

  localparam int unsigned WIDTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    UNCOMP = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rev_mux_sequencer.sv
// Drives revMUX12 with a zero ancilla, captures x_out, then uncomputes by
// feeding the result back and checking the ancilla returns to zero.
module rev_mux_sequencer
  import rev_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  output logic [WIDTH-1:0] mux_a,
  output logic [WIDTH-1:0] mux_b,
  output logic             mux_s,
  output logic [WIDTH-1:0] mux_x,
  input  logic [WIDTH-1:0] ret_a,
  input  logic [WIDTH-1:0] ret_b,
  input  logic             ret_s,
  input  logic [WIDTH-1:0] ret_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] mux_a_n, mux_b_n, mux_x_n;
  logic             mux_s_n;
  logic [WIDTH-1:0] result, result_n;
  logic             err, err_n;
  logic             out_valid_n;
  logic [WIDTH-1:0] out_data_n;
  logic             out_err_n;

  // Ready only in IDLE, and never while reset is asserted.
  assign in_ready = (state == IDLE) & ~rst;

  // State, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mux_a     <= '0;
      mux_b     <= '0;
      mux_s     <= 1'b0;
      mux_x     <= '0;
      result    <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mux_a     <= mux_a_n;
      mux_b     <= mux_b_n;
      mux_s     <= mux_s_n;
      mux_x     <= mux_x_n;
      result    <= result_n;
      err       <= err_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_err   <= out_err_n;
    end
  end

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mux_a_n     = mux_a;
    mux_b_n     = mux_b;
    mux_s_n     = mux_s;
    mux_x_n     = mux_x;
    result_n    = result;
    err_n       = err;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_err_n   = out_err;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          mux_a_n = in_a;
          mux_b_n = in_b;
          mux_s_n = in_sel;
          mux_x_n = '0;
          cnt_n   = '0;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == SETTLE_C) begin
          // Compute pass: capture result and check operand passthrough.
          result_n = ret_x;
          err_n    = (ret_a != mux_a) | (ret_b != mux_b) | (ret_s != mux_s);
          mux_x_n  = ret_x;
          cnt_n    = '0;
          state_n  = UNCOMP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      UNCOMP: begin
        if (cnt == SETTLE_C) begin
          // Uncompute pass: ancilla must be back at zero.
          out_data_n  = result;
          out_err_n   = err | (ret_x != '0);
          out_valid_n = 1'b1;
          mux_a_n     = '0;
          mux_b_n     = '0;
          mux_s_n     = 1'b0;
          mux_x_n     = '0;
          cnt_n       = '0;
          state_n     = RESP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rev_mux_sequencer.sv
// Directed bench: sequencer wired to a behavioural revMUX12 with fault knobs,
// plus a second SETTLE=0 instance for back-to-back throughput.
module tb_rev_mux_sequencer;

  localparam int unsigned W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // SETTLE=1 instance
  logic         in_valid = 1'b0, in_sel = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, mux_s, ret_s, out_valid, out_err;
  logic [W-1:0] mux_a, mux_b, mux_x, ret_a, ret_b, ret_x, out_data;
  logic         flt_b = 1'b0, flt_x = 1'b0;

  // revMUX12 model: x_out = x_in ^ (s ? b : a), with optional faults
  assign ret_a = mux_a;
  assign ret_b = mux_b ^ W'(flt_b);
  assign ret_s = mux_s;
  assign ret_x = flt_x ? W'(1) : (mux_x ^ (mux_s ? mux_b : mux_a));

  rev_mux_sequencer #(.WIDTH(W), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .mux_a(mux_a), .mux_b(mux_b), .mux_s(mux_s), .mux_x(mux_x),
    .ret_a(ret_a), .ret_b(ret_b), .ret_s(ret_s), .ret_x(ret_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  // SETTLE=0 instance with a clean mux model
  logic         in_valid0 = 1'b0, in_sel0 = 1'b0, out_ready0 = 1'b1;
  logic [W-1:0] in_a0 = '0, in_b0 = '0;
  logic         in_ready0, mux_s0, out_valid0, out_err0;
  logic [W-1:0] mux_a0, mux_b0, mux_x0, ret_x0, out_data0;

  assign ret_x0 = mux_x0 ^ (mux_s0 ? mux_b0 : mux_a0);

  rev_mux_sequencer #(.WIDTH(W), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .in_sel(in_sel0),
    .mux_a(mux_a0), .mux_b(mux_b0), .mux_s(mux_s0), .mux_x(mux_x0),
    .ret_a(mux_a0), .ret_b(mux_b0), .ret_s(mux_s0), .ret_x(ret_x0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_err(out_err0)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request to u_dut for a single edge (DUT assumed in IDLE)
  task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    in_a = a; in_b = b; in_sel = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles until out_valid, bounded; returns 99 on timeout
  task automatic wait_valid(input int already, output int lat);
    lat = already;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if ({mux_a, mux_b, mux_s, mux_x} !== '0) begin
      failures++; $display("FAIL reset_mux got=%h/%h/%b/%h exp=0", mux_a, mux_b, mux_s, mux_x);
    end
    checks++;
    if ({out_valid, out_data, out_err} !== '0) begin
      failures++; $display("FAIL reset_out got=%b/%h/%b exp=0", out_valid, out_data, out_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_select_a();
    int lat;
    out_ready = 1'b1;
    start_req(12'h00F, 12'h0FF, 1'b0);
    wait_valid(0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL sel_a_latency got=%0d exp=4", lat); end
    checks++;
    if (out_data !== 12'h00F || out_err !== 1'b0) begin
      failures++; $display("FAIL sel_a_result got=%h err=%b exp=00f err=0", out_data, out_err);
    end
    checks++;
    if ({mux_a, mux_b, mux_s, mux_x} !== '0) begin
      failures++; $display("FAIL sel_a_mux_cleared got=%h/%h/%b/%h exp=0", mux_a, mux_b, mux_s, mux_x);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mux_x !== '0) begin
      failures++; $display("FAIL sel_a_done got=v%b r%b x%h exp=v0 r1 x000", out_valid, in_ready, mux_x);
    end
  endtask

  task automatic test_select_b();
    int lat;
    start_req(12'h00F, 12'h0FF, 1'b1);
    tick();
    tick();
    checks++;
    if (mux_x !== 12'h0FF) begin failures++; $display("FAIL uncomp_mux_x got=%h exp=0ff", mux_x); end
    wait_valid(2, lat);
    checks++;
    if (lat !== 4 || out_data !== 12'h0FF || out_err !== 1'b0) begin
      failures++; $display("FAIL sel_b_result got=%h err=%b lat=%0d exp=0ff err=0 lat=4", out_data, out_err, lat);
    end
    tick();
  endtask

  task automatic test_faults();
    int lat;
    flt_b = 1'b1;
    start_req(12'h123, 12'h456, 1'b0);
    wait_valid(0, lat);
    checks++;
    if (lat !== 4 || out_data !== 12'h123 || out_err !== 1'b1) begin
      failures++; $display("FAIL fault_b got=%h err=%b lat=%0d exp=123 err=1 lat=4", out_data, out_err, lat);
    end
    tick();
    flt_b = 1'b0;
    flt_x = 1'b1;
    start_req(12'h321, 12'h654, 1'b1);
    wait_valid(0, lat);
    checks++;
    if (lat !== 4 || out_data !== 12'h001 || out_err !== 1'b1) begin
      failures++; $display("FAIL fault_x got=%h err=%b lat=%0d exp=001 err=1 lat=4", out_data, out_err, lat);
    end
    tick();
    flt_x = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_req(12'h5A5, 12'h3C3, 1'b1);
    wait_valid(0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 12'h3C3 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got=v%b d%h e%b r%b exp=v1 d3c3 e0 r0", i, out_valid, out_data, out_err, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    start_req(12'h777, 12'h888, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({mux_a, mux_b, mux_s, mux_x, out_valid, out_data, out_err, in_ready} !== '0) begin
      failures++;
      $display("FAIL abort_immediate got=%h/%h/%b/%h v%b d%h e%b r%b exp=all0",
               mux_a, mux_b, mux_s, mux_x, out_valid, out_data, out_err, in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_after got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
    start_req(12'hABC, 12'h111, 1'b0);
    wait_valid(0, lat);
    checks++;
    if (lat !== 4 || out_data !== 12'hABC || out_err !== 1'b0) begin
      failures++; $display("FAIL abort_recover got=%h err=%b lat=%0d exp=abc err=0 lat=4", out_data, out_err, lat);
    end
    tick();
  endtask

  // With SETTLE=0 a request takes accept, compute, uncompute edges, then the
  // RESP handshake edge; in_ready rises after that, so accepts are 4 edges apart.
  task automatic test_back_to_back();
    logic [W-1:0] va[3], vb[3], ve[3];
    logic         vs[3];
    int           acc_cyc[3];
    int           nacc, nres;
    logic         acc;
    va = '{12'h001, 12'h0AA, 12'hFFF};
    vb = '{12'h002, 12'h055, 12'h800};
    vs = '{1'b1, 1'b0, 1'b1};
    ve = '{12'h002, 12'h0AA, 12'h800};
    nacc = 0;
    nres = 0;
    out_ready0 = 1'b1;
    in_a0 = va[0]; in_b0 = vb[0]; in_sel0 = vs[0]; in_valid0 = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (out_valid0) begin
        checks++;
        if (nres >= 3 || out_data0 !== ve[nres % 3] || out_err0 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_result%0d got=%h err=%b exp=%h err=0", nres, out_data0, out_err0, ve[nres % 3]);
        end
        nres++;
      end
      acc = in_valid0 & in_ready0;
      tick();
      if (acc) begin
        acc_cyc[nacc] = c;
        nacc++;
        if (nacc < 3) begin
          in_a0 = va[nacc]; in_b0 = vb[nacc]; in_sel0 = vs[nacc];
        end else begin
          in_valid0 = 1'b0;
        end
      end
    end
    checks++;
    if (nacc !== 3 || nres !== 3) begin
      failures++; $display("FAIL b2b_counts got=acc%0d res%0d exp=acc3 res3", nacc, nres);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (acc_cyc[i+1] - acc_cyc[i] !== 4) begin
          failures++; $display("FAIL b2b_spacing%0d got=%0d exp=4", i, acc_cyc[i+1] - acc_cyc[i]);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_select_a();
    test_select_b();
    test_faults();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
